// File: rtl/spike_timestep_sequencer.sv
// Steps timesteps 0..N-1 through the spike pattern memory and streams vectors.
// Optional SPIKE_SEQ_LOOP_EN: repeat the run until abort or reset.
module spike_timestep_sequencer #(
  parameter int NUM_SPIKES          = 100,
  parameter int TIMESTEP_ADDR_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [TIMESTEP_ADDR_WIDTH:0]   num_timesteps,
  output logic [TIMESTEP_ADDR_WIDTH-1:0] mem_addr,
  input  logic [NUM_SPIKES-1:0]          mem_spikes,
  output logic [NUM_SPIKES-1:0]          spike_out,
  output logic                           spike_valid,
  input  logic                           spike_ready,
  output logic [TIMESTEP_ADDR_WIDTH-1:0] timestep,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = TIMESTEP_ADDR_WIDTH;
  localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_cnt;
  logic [AW-1:0]         r_last;
  logic [AW-1:0]         r_ts;
  logic [NUM_SPIKES-1:0] r_spike;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [AW:0]           w_n_clamped;
  logic [AW-1:0]         w_last;
  logic                  w_n_zero;
  logic                  w_hs;
  logic                  w_at_last;

  // Clamp the requested run length and precompute the final counter value.
  always_comb begin
    w_n_clamped = num_timesteps;
    if (num_timesteps > MAX_N) begin
      w_n_clamped = MAX_N;
    end
    w_last    = AW'(w_n_clamped - (AW+1)'(1));
    w_n_zero  = (num_timesteps == '0);
    w_hs      = r_valid && spike_ready;
    w_at_last = (r_cnt == r_last);
  end

  // Run sequencer: abort beats start and the handshake; outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_ts    <= '0;
      r_spike <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_last <= w_last;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_n_zero) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_done  <= 1'b0;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_spike <= mem_spikes;
          r_ts    <= r_cnt;
          r_valid <= 1'b1;
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_at_last) begin
`ifdef SPIKE_SEQ_LOOP_EN
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= S_FETCH;
`else
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_cnt   <= r_cnt + AW'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = r_cnt;
  assign timestep    = r_ts;
  assign spike_out   = r_spike;
  assign spike_valid = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_spike_timestep_sequencer.sv
// Scoreboard bench for spike_timestep_sequencer (default single-pass build).
// Expected vectors are queued at start and popped on each handshake.
module tb_spike_timestep_sequencer;

  localparam int NS = 100;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] ts;
    logic [NS-1:0] d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   nts;
  logic [AW-1:0] mem_addr;
  logic [NS-1:0] mem_q;
  logic [NS-1:0] spike_out;
  logic          spike_valid;
  logic          spike_ready;
  logic [AW-1:0] timestep;
  logic          busy;
  logic          done;

  logic [NS-1:0] mem [DEPTH];
  exp_t          q[$];
  int            checks;
  int            errors;
  int            n_hs;

  spike_timestep_sequencer #(
    .NUM_SPIKES(NS),
    .TIMESTEP_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .num_timesteps(nts),
    .mem_addr(mem_addr),
    .mem_spikes(mem_q),
    .spike_out(spike_out),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .timestep(timestep),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read pattern memory
  always @(posedge clk) mem_q <= mem[mem_addr];

  // scoreboard: compare every accepted vector against the queue head
  always @(negedge clk) begin
    if (rst_n && spike_valid && spike_ready && !abort) begin
      n_hs++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ts=%0d data=%h, required no handshake",
                 timestep, spike_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (timestep !== e.ts || spike_out !== e.d) begin
          errors++;
          $display("FAIL sb_vector: got ts=%0d data=%h, required ts=%0d data=%h",
                   timestep, spike_out, e.ts, e.d);
        end
      end
    end
  end

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ts = AW'(i);
      e.d  = mem[i];
      q.push_back(e);
    end
  endtask

  task automatic kick(input int n);
    @(posedge clk); #1;
    nts   = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({spike_valid, busy, done} !== 3'b000 || mem_addr !== '0 ||
        timestep !== '0 || spike_out !== '0) begin
      errors++;
      $display("FAIL reset_vals: got v=%b b=%b d=%b a=%0d ts=%0d so=%h, required all 0",
               spike_valid, busy, done, mem_addr, timestep, spike_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int vc[$];
    int dc[$];
    mem[0] = 100'h1;
    mem[1] = 100'h2;
    mem[2] = 100'h4;
    mem[3] = 100'h8;
    spike_ready = 1'b1;
    push_run(4);
    kick(4);
    for (int c = 1; c <= 20; c++) begin
      if (spike_valid) vc.push_back(c);
      if (done) dc.push_back(c);
      if (c == 13) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_done: got %b, required 1", busy);
        end
      end
      if (c == 14) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_busy_fall: got %b, required 0", busy);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (vc.size() != 4) begin
      errors++;
      $display("FAIL basic_nvalid: got %0d cycles, required 4", vc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (vc[i] != 3 + 3 * i) begin
          errors++;
          $display("FAIL basic_valid_cycle: got %0d, required %0d", vc[i], 3 + 3 * i);
        end
      end
    end
    checks++;
    if (dc.size() != 1 || dc[0] != 13) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first=%0d, required 1 at 13",
               dc.size(), (dc.size() > 0) ? dc[0] : -1);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d left, required 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_stall;
    bit hit;
    hit = 1'b0;
    spike_ready = 1'b1;
    push_run(3);
    kick(3);
    for (int c = 0; c < 30; c++) begin
      if (spike_valid && timestep == 1) begin
        spike_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL stall_reach: got no ts1, required ts1 within 30 cycles");
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (spike_valid !== 1'b1 || timestep !== 8'd1 ||
          spike_out !== mem[1] || mem_addr !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold: got v=%b ts=%0d a=%0d so=%h, required v=1 ts=1 a=1 so=%h",
                 spike_valid, timestep, mem_addr, spike_out, mem[1]);
      end
    end
    spike_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit || q.size() != 0) begin
      errors++;
      $display("FAIL stall_finish: got done=%b left=%0d, required done=1 left=0",
               hit, q.size());
    end
    q.delete();
  endtask

  task automatic test_zero;
    int h0;
    h0 = n_hs;
    kick(0);
    checks++;
    if (done !== 1'b1 || spike_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got d=%b v=%b b=%b, required d=1 v=0 b=1",
               done, spike_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || n_hs != h0) begin
      errors++;
      $display("FAIL zero_end: got d=%b b=%b hs=%0d, required d=0 b=0 hs=0",
               done, busy, n_hs - h0);
    end
  endtask

  task automatic test_clamp;
    int  h0;
    bit  hit;
    h0  = n_hs;
    hit = 1'b0;
    spike_ready = 1'b1;
    push_run(DEPTH);
    kick(DEPTH + 5);
    for (int c = 0; c < 900; c++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL clamp_timeout: got no done, required done within 900 cycles");
    end
    checks++;
    if (n_hs - h0 != DEPTH || q.size() != 0) begin
      errors++;
      $display("FAIL clamp_count: got %0d vectors left=%0d, required %0d left=0",
               n_hs - h0, q.size(), DEPTH);
    end
    checks++;
    if (mem_addr !== 8'd255) begin
      errors++;
      $display("FAIL clamp_last_addr: got %0d, required 255", mem_addr);
    end
    q.delete();
  endtask

  task automatic test_abort;
    bit hit;
    hit = 1'b0;
    spike_ready = 1'b1;
    push_run(5);
    kick(5);
    for (int c = 0; c < 30; c++) begin
      if (spike_valid && timestep == 1) break;
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (spike_valid && timestep == 2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach: got no ts2, required ts2 within 30 cycles");
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (spike_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got v=%b b=%b d=%b, required 0 0 0",
               spike_valid, busy, done);
    end
    checks++;
    if (q.size() != 3) begin
      errors++;
      $display("FAIL abort_left: got %0d pending, required 3", q.size());
    end
    q.delete();
    hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy || spike_valid) hit = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (hit) begin
      errors++;
      $display("FAIL abort_quiet: got activity after abort, required none");
    end
  endtask

  task automatic test_reset_mid;
    spike_ready = 1'b1;
    push_run(3);
    kick(3);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({spike_valid, busy, done} !== 3'b000 || mem_addr !== '0 ||
        timestep !== '0 || spike_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b b=%b d=%b a=%0d ts=%0d so=%h, required all 0",
               spike_valid, busy, done, mem_addr, timestep, spike_out);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got b=%b d=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    n_hs        = 0;
    start       = 1'b0;
    abort       = 1'b0;
    nts         = '0;
    spike_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, 4'($urandom)};
    end
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_clamp();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
